// File: rtl/easyaxi_wrr_arb.sv
// ---------------------------------------------------------------------------
// easyaxi_wrr_arb
//   Weighted round-robin arbiter with a registered valid/ready grant
//   handshake. Each requester keeps the grant for up to its programmed
//   weight of consecutive accepted transfers; priority then rotates past it.
//   A weight of 0 behaves as 1.
//
// Build option:
//   EASYAXI_WRR_ARB_LOCK_EN  - when defined, last_i is honoured and the grant
//                              is held until the owner's last beat, so credit
//                              counts bursts. When undefined every handshake
//                              ends a transfer and last_i is ignored.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_i        per-requester request
//   weight_i     weight of requester k in bits [k*WEIGHT_W +: WEIGHT_W]
//   last_i       per-requester last-beat flag (owner only, at handshake)
//   grant_rdy_i  downstream accepts the current grant/beat
//   grant_vld_o  grant valid
//   grant_o      one-hot owner, all-zero while idle
//   grant_idx_o  binary owner index, holds its last value while idle
// ---------------------------------------------------------------------------
module easyaxi_wrr_arb #(
    parameter  int REQ_NUM  = 4,
    parameter  int WEIGHT_W = 4,
    localparam int IDX_W    = $clog2(REQ_NUM)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [REQ_NUM-1:0]          req_i,
    input  logic [REQ_NUM*WEIGHT_W-1:0] weight_i,
    input  logic [REQ_NUM-1:0]          last_i,
    input  logic                        grant_rdy_i,
    output logic                        grant_vld_o,
    output logic [REQ_NUM-1:0]          grant_o,
    output logic [IDX_W-1:0]            grant_idx_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [REQ_NUM-1:0]   grant_q, grant_nxt;
    logic [IDX_W-1:0]     idx_q, idx_nxt;
    logic [IDX_W-1:0]     last_ptr, ptr_nxt;
    logic [WEIGHT_W-1:0]  credit, credit_nxt;

    logic                 any_req;
    logic                 found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand;
    int unsigned          scan_pos;
    logic [WEIGHT_W-1:0]  eff_w [REQ_NUM];
    logic                 burst_end;
    logic                 do_load;

    // Effective weights: a zero weight still grants one transfer.
    always_comb begin
        for (int unsigned k = 0; k < unsigned'(REQ_NUM); k++) begin
            eff_w[k] = (weight_i[k*WEIGHT_W +: WEIGHT_W] == '0)
                       ? WEIGHT_W'(1)
                       : weight_i[k*WEIGHT_W +: WEIGHT_W];
        end
    end

    // Rotating priority search starting just after last_ptr. The previous
    // owner is visited last, so it only wins again if it is alone.
    assign any_req = |req_i;

    always_comb begin
        win_idx  = '0;
        found    = 1'b0;
        scan_pos = 0;
        cand     = '0;
        for (int unsigned i = 1; i <= unsigned'(REQ_NUM); i++) begin
            scan_pos = 32'(last_ptr) + i;
            if (scan_pos >= unsigned'(REQ_NUM)) begin
                scan_pos = scan_pos - unsigned'(REQ_NUM);
            end
            cand = IDX_W'(scan_pos);
            if (!found && req_i[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

`ifdef EASYAXI_WRR_ARB_LOCK_EN
    assign burst_end = last_i[idx_q];
`else
    logic lock_unused;
    assign lock_unused = ^last_i;
    assign burst_end   = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            last_ptr <= IDX_W'(REQ_NUM - 1);
            credit   <= '0;
        end else begin
            state    <= state_nxt;
            grant_q  <= grant_nxt;
            idx_q    <= idx_nxt;
            last_ptr <= ptr_nxt;
            credit   <= credit_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant_q;
        idx_nxt    = idx_q;
        ptr_nxt    = last_ptr;
        credit_nxt = credit;
        do_load    = 1'b0;

        unique case (state)
            IDLE: begin
                if (any_req) begin
                    do_load = 1'b1;
                end
            end
            GRANT: begin
                // Without a handshake everything holds, whatever req_i does.
                // A handshake that is not a burst end also holds.
                if (grant_rdy_i && burst_end) begin
                    if (credit > WEIGHT_W'(1) && req_i[idx_q]) begin
                        credit_nxt = credit - WEIGHT_W'(1);
                    end else if (any_req) begin
                        do_load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (do_load) begin
            state_nxt          = GRANT;
            grant_nxt          = '0;
            grant_nxt[win_idx] = 1'b1;
            idx_nxt            = win_idx;
            ptr_nxt            = win_idx;
            credit_nxt         = eff_w[win_idx];
        end
    end

    assign grant_vld_o = (state == GRANT);
    assign grant_o     = grant_q;
    assign grant_idx_o = idx_q;

endmodule

// File: tb/tb_easyaxi_wrr_arb.sv
// ---------------------------------------------------------------------------
// tb_easyaxi_wrr_arb
//   Self-checking bench for easyaxi_wrr_arb (REQ_NUM=4, WEIGHT_W=4).
//   Expected owners are queued when stimulus is applied; a monitor pops one
//   entry per accepted grant and compares owner index, one-hot grant and,
//   where flagged, that the grant followed the previous one with no bubble.
// ---------------------------------------------------------------------------
module tb_easyaxi_wrr_arb;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] weight;
    logic [N-1:0]   last;
    logic           rdy;
    logic           vld;
    logic [N-1:0]   grant;
    logic [1:0]     idx;

    easyaxi_wrr_arb #(
        .REQ_NUM  (N),
        .WEIGHT_W (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .weight_i    (weight),
        .last_i      (last),
        .grant_rdy_i (rdy),
        .grant_vld_o (vld),
        .grant_o     (grant),
        .grant_idx_o (idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned owner;
        bit          b2b;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned last_hs_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic push(input int unsigned owner, input bit b2b);
        exp_t e;
        e.owner = owner;
        e.b2b   = b2b;
        exp_q.push_back(e);
    endtask

    // Scoreboard consumer: one entry per accepted grant.
    always @(negedge clk) begin
        exp_t       e;
        logic [N-1:0] oh;
        if (rst_n === 1'b1 && vld === 1'b1 && rdy === 1'b1 && exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            oh = N'(1) << e.owner;
            check("owner_idx", 32'(idx), e.owner);
            check("owner_onehot", 32'(grant), 32'(oh));
            if (e.b2b) check("no_bubble", cyc - last_hs_cyc, 1);
            last_hs_cyc = cyc;
        end
    end

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        check({"drain_", tag}, 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    // Asserts reset mid-cycle, checks the outputs clear immediately, then
    // releases just after a rising edge with default stimulus.
    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        req    = '0;
        rdy    = 1'b0;
        last   = '1;
        weight = {N{4'd1}};
        #1;
        check("rst_vld", 32'(vld), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_idx", 32'(idx), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        req    = '0;
        rdy    = 1'b0;
        last   = '1;
        weight = {N{4'd1}};

        // Plain round robin, first grant one cycle after the request.
        apply_reset();
        push(0, 0); push(1, 1); push(2, 1); push(3, 1); push(0, 1);
        req = 4'b1111;
        rdy = 1'b1;
        @(negedge clk);
        check("latency_pre_vld", 32'(vld), 0);
        @(negedge clk);
        check("latency_post_vld", 32'(vld), 1);
        wait_drain("rr");

        // Weighted sequence, weight 0 acts as 1.
        apply_reset();
        weight = {4'd2, 4'd0, 4'd1, 4'd3};
        push(0, 0); push(0, 1); push(0, 1); push(1, 1);
        push(2, 1); push(3, 1); push(3, 1); push(0, 1);
        req = 4'b1111;
        rdy = 1'b1;
        wait_drain("wrr");

        // Backpressure on owner 2 with req_i churning underneath.
        apply_reset();
        req = 4'b0100;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            req = 4'($urandom_range(0, 15));
            @(negedge clk);
            check("bp_vld", 32'(vld), 1);
            check("bp_grant", 32'(grant), 32'(4'b0100));
            @(posedge clk);
            #1;
        end
        push(2, 0); push(3, 1); push(0, 1);
        req = 4'b1111;
        rdy = 1'b1;
        wait_drain("bp");

        // Early release: owner 0 drops its request before spending its weight.
        apply_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd4};
        push(0, 0); push(0, 1); push(1, 1);
        req = 4'b0011;
        rdy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req = 4'b0010;
        @(posedge clk); #1;
        req = 4'b0000;
        @(posedge clk); #1;
        @(negedge clk);
        check("release_vld", 32'(vld), 0);
        check("release_grant", 32'(grant), 0);
        wait_drain("release");

        // Four-beat burst from owner 0 against a single-beat requester 1.
        apply_reset();
`ifdef EASYAXI_WRR_ARB_LOCK_EN
        push(0, 0); push(0, 1); push(0, 1); push(0, 1); push(1, 1);
`else
        push(0, 0); push(1, 1); push(0, 1); push(1, 1);
`endif
        last = 4'b0010;
        req  = 4'b0011;
        rdy  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        last = 4'b0011;
        wait_drain("burst");

        // Asynchronous reset while owner 3 is mid-weight.
        apply_reset();
        weight = {4'd3, 4'd1, 4'd1, 4'd1};
        push(3, 0);
        req = 4'b1000;
        rdy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #3;
        check("pre_async_vld", 32'(vld), 1);
        rst_n = 1'b0;
        #1;
        check("async_vld", 32'(vld), 0);
        check("async_grant", 32'(grant), 0);
        check("async_idx", 32'(idx), 0);
        check("async_drain", 32'(exp_q.size()), 0);
        exp_q.delete();
        req = 4'b1001;
        push(0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_drain("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
